// File: rtl/coin_feeder.sv
// ---------------------------------------------------------------------------
// coin_feeder
//
// Host-side driver for the vending machine coin interface. An amount request
// (in 5c units) is taken over a valid/ready handshake. It is sent as a train
// of one-cycle coin codes on `coins`, with GAP idle cycles between coins.
// After the last coin the block keeps counting `coffee` pulses for WAIT_CYC
// cycles. It then reports the total on `coffee_count` with a one-cycle `done`.
//
// Parameters
//   AMT_W     width of req_amount and coffee_count
//   GAP       idle (00) cycles between coins, 0 = back-to-back
//   WAIT_CYC  idle cycles after the last coin before done
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous reset, active low
//   req_valid     request strobe
//   req_ready     high only while idle; transfer on valid & ready
//   req_amount    amount in 5c units
//   req_prefer5   1 = send only 5c coins
//   coins         00 none, 01 10c coin, 10 5c coin (11 is never driven)
//   coffee        coffee pulse from the vending FSM
//   busy          high while a transaction is in flight (SEND/GAP/WAIT/DONE)
//   done          one-cycle pulse at the end of a transaction
//   coffee_count  coffees seen in the last transaction, saturating
// ---------------------------------------------------------------------------
module coin_feeder #(
  parameter int AMT_W    = 6,
  parameter int GAP      = 1,
  parameter int WAIT_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             req_prefer5,
  output logic [1:0]       coins,
  input  logic             coffee,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] coffee_count
);

  // One down-counter times both the inter-coin gap and the final wait, so it
  // is sized for whichever is longer.
  localparam int MAX_DLY = (GAP > WAIT_CYC) ? GAP : WAIT_CYC;
  localparam int CNT_W   = (MAX_DLY < 2) ? 1 : $clog2(MAX_DLY + 1);

  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP > 0)      ? CNT_W'(GAP - 1)      : '0;
  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_10C  = 2'b01;
  localparam logic [1:0] COIN_5C   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] remaining_nxt;
  logic             prefer5;
  logic             prefer5_nxt;
  logic [CNT_W-1:0] dly;
  logic [CNT_W-1:0] dly_nxt;
  logic [1:0]       coins_nxt;
  logic             done_nxt;
  logic [AMT_W-1:0] count_nxt;
  logic [AMT_W-1:0] remaining_after;

  // Handshake and busy are pure decodes of the state, so they are valid
  // (ready=1) even while reset is held.
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // Next-state, datapath and registered-output values.
  // A coin chosen in SEND is registered, so it appears on `coins` during the
  // following cycle (GAP, SEND or the first WAIT cycle).
  always_comb begin
    state_nxt       = state;
    remaining_nxt   = remaining;
    prefer5_nxt     = prefer5;
    dly_nxt         = dly;
    coins_nxt       = COIN_NONE;
    count_nxt       = coffee_count;
    remaining_after = remaining;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          remaining_nxt = req_amount;
          prefer5_nxt   = req_prefer5;
          count_nxt     = '0;
          state_nxt     = (req_amount == '0) ? S_DONE : S_SEND;
        end
      end

      S_SEND: begin
        // 10c coins go first; a leftover odd 5c is therefore always the
        // last coin of the train.
        if (!prefer5 && (remaining > AMT_W'(1))) begin
          coins_nxt       = COIN_10C;
          remaining_after = remaining - AMT_W'(2);
        end else begin
          coins_nxt       = COIN_5C;
          remaining_after = remaining - AMT_W'(1);
        end
        remaining_nxt = remaining_after;

        if (remaining_after == '0) begin
          if (WAIT_CYC == 0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
            dly_nxt   = WAIT_LOAD;
          end
        end else if (GAP == 0) begin
          state_nxt = S_SEND;
        end else begin
          state_nxt = S_GAP;
          dly_nxt   = GAP_LOAD;
        end
      end

      S_GAP: begin
        if (dly == '0) begin
          state_nxt = S_SEND;
        end else begin
          dly_nxt = dly - CNT_W'(1);
        end
      end

      S_WAIT: begin
        if (dly == '0) begin
          state_nxt = S_DONE;
        end else begin
          dly_nxt = dly - CNT_W'(1);
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Coffee is only counted while the transaction is live. The count sticks
    // at all-ones rather than wrapping.
    if (((state == S_SEND) || (state == S_GAP) || (state == S_WAIT)) &&
        coffee && (coffee_count != '1)) begin
      count_nxt = coffee_count + AMT_W'(1);
    end

    done_nxt = (state_nxt == S_DONE);
  end

  // State and registered outputs. Reset discards any partial transaction
  // without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      remaining    <= '0;
      prefer5      <= 1'b0;
      dly          <= '0;
      coins        <= COIN_NONE;
      done         <= 1'b0;
      coffee_count <= '0;
    end else begin
      state        <= state_nxt;
      remaining    <= remaining_nxt;
      prefer5      <= prefer5_nxt;
      dly          <= dly_nxt;
      coins        <= coins_nxt;
      done         <= done_nxt;
      coffee_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_coin_feeder.sv
// ---------------------------------------------------------------------------
// tb_coin_feeder
//
// Directed and random transactions for coin_feeder. The expected coin train,
// busy/done timing and coffee count are derived from each request's amount
// with plain arithmetic:
//   coin k appears 2 + k*(GAP+1) cycles after accept;
//   done comes WAIT_CYC cycles after the last coin.
// ---------------------------------------------------------------------------
module tb_coin_feeder;

  localparam int AMT_W    = 6;
  localparam int GAP      = 1;
  localparam int WAIT_CYC = 2;
  localparam int MAXC     = (1 << AMT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount;
  logic             req_prefer5;
  logic [1:0]       coins;
  logic             coffee;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] coffee_count;

  int errors   = 0;
  int checks   = 0;
  int curCycle = 0;

  coin_feeder #(
    .AMT_W   (AMT_W),
    .GAP     (GAP),
    .WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_amount  (req_amount),
    .req_prefer5 (req_prefer5),
    .coins       (coins),
    .coffee      (coffee),
    .busy        (busy),
    .done        (done),
    .coffee_count(coffee_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h",
             tag, curCycle, observed, expected);
    end
  endtask

  // Runs one transaction, entered and left at a falling edge with the DUT idle.
  //   pulses >= 0 : coffee high for `pulses` cycles starting at the last coin
  //   pulses == -1: random coffee every cycle
  //   pulses == -2: coffee always high
  //   holdValid   : keep req_valid high and scramble the request while busy
  //   abortAt     : cycle at which reset is pulled mid-transaction (0 = never)
  task automatic applyStimulus(input int amount, input bit prefer5, input int pulses,
                               input bit holdValid, input int abortAt);
    int       nTen;
    int       nCoin;
    int       tLast;
    int       tDone;
    int       coffeeSum;
    int       k;
    int       expCount;
    logic [1:0] expCoin;
    logic     cf;

    nTen  = prefer5 ? 0 : amount / 2;
    nCoin = amount - nTen;
    if (amount == 0) begin
      tLast = 0;
      tDone = 1;
    end else begin
      tLast = 2 + (nCoin - 1) * (GAP + 1);
      tDone = tLast + WAIT_CYC;
    end
    coffeeSum = 0;
    curCycle  = 0;

    req_valid   = 1'b1;
    req_amount  = amount[AMT_W-1:0];
    req_prefer5 = prefer5;
    coffee      = 1'($urandom_range(0, 1));
    checkOutput("ready_at_request", 32'(req_ready), 32'd1);

    @(posedge clk);
    if (!holdValid) begin
      #1 req_valid = 1'b0;
    end

    for (int t = 1; t <= tDone + 1; t++) begin
      @(negedge clk);
      curCycle = t;

      expCoin = 2'b00;
      if ((amount > 0) && (t >= 2) && (((t - 2) % (GAP + 1)) == 0)) begin
        k = (t - 2) / (GAP + 1);
        if (k < nCoin) expCoin = (k < nTen) ? 2'b01 : 2'b10;
      end
      expCount = (coffeeSum > MAXC) ? MAXC : coffeeSum;

      checkOutput("coins",        32'(coins),        32'(expCoin));
      checkOutput("busy",         32'(busy),         32'(t <= tDone));
      checkOutput("req_ready",    32'(req_ready),    32'(t > tDone));
      checkOutput("done",         32'(done),         32'(t == tDone));
      checkOutput("coffee_count", 32'(coffee_count), expCount);

      if (pulses == -2)      cf = 1'b1;
      else if (pulses == -1) cf = 1'($urandom_range(0, 1));
      else                   cf = ((t >= tLast) && (t < tLast + pulses));
      coffee = cf;
      if (cf && (t <= tDone - 1)) coffeeSum++;

      if (holdValid) begin
        req_valid   = 1'b1;
        req_amount  = AMT_W'($urandom);
        req_prefer5 = 1'($urandom_range(0, 1));
      end

      if (t == abortAt) begin
        #2 reset = 1'b0;
        #1;
        checkOutput("coins_async_reset", 32'(coins),        32'd0);
        checkOutput("busy_async_reset",  32'(busy),         32'd0);
        checkOutput("ready_in_reset",    32'(req_ready),    32'd1);
        checkOutput("done_async_reset",  32'(done),         32'd0);
        checkOutput("count_async_reset", 32'(coffee_count), 32'd0);
        coffee    = 1'b0;
        req_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("done_in_reset",  32'(done),  32'd0);
          checkOutput("coins_in_reset", 32'(coins), 32'd0);
        end
        reset = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_amount  = '0;
    req_prefer5 = 1'b0;
    coffee      = 1'b0;

    #2;
    checkOutput("reset_ready", 32'(req_ready),    32'd1);
    checkOutput("reset_busy",  32'(busy),         32'd0);
    checkOutput("reset_coins", 32'(coins),        32'd0);
    checkOutput("reset_done",  32'(done),         32'd0);
    checkOutput("reset_count", 32'(coffee_count), 32'd0);

    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] T1 amount=3 10c-first");
    applyStimulus(3, 1'b0, 1, 1'b0, 0);
    $display("[TB] T2 amount=6 10c-first");
    applyStimulus(6, 1'b0, 2, 1'b0, 0);
    $display("[TB] T3 amount=3 5c only");
    applyStimulus(3, 1'b1, 1, 1'b0, 0);
    $display("[TB] T4 amount=0");
    applyStimulus(0, 1'b0, -1, 1'b0, 0);
    $display("[TB] T5 reset during second gap, then amount=2");
    applyStimulus(6, 1'b0, -1, 1'b0, 4);
    applyStimulus(2, 1'b0, -1, 1'b0, 0);
    $display("[TB] T6 valid held while busy, back-to-back accept, saturation");
    applyStimulus(5, 1'b0, -1, 1'b1, 0);
    applyStimulus(63, 1'b1, -2, 1'b1, 0);
    req_valid = 1'b0;
    @(negedge clk);

    $display("[TB] random transactions");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), -1, 1'b0, 0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
